// File: rtl/conv_tp_pkg.sv
// Shared types and sizing helpers for the streaming transposed-convolution engine.
package conv_tp_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_ACCEPT,
    ST_SCATTER,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ACC_NOP,
    ACC_CLEAR,
    ACC_ADD,
    ACC_READ
  } acc_op_e;

  function automatic int out_dim(input int in_dim, input int stride, input int k);
    return (in_dim - 1) * stride + k;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_tp_acc_map.sv
// Output-map accumulator array with a single read-modify-write port (clear/add/read).
module conv_tp_acc_map
  import conv_tp_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 91,
  parameter int ADDR_W = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  acc_op_e           op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ACC_W-1:0]  add_val,
  output logic [ACC_W-1:0]  rd_data
);

  logic [ACC_W-1:0] mem_q [DEPTH];
  logic [ACC_W-1:0] mem_d [DEPTH];
  logic             addr_ok;

  assign addr_ok = int'(addr) < DEPTH;

  always_comb begin
    mem_d = mem_q;
    if (addr_ok) begin
      case (op)
        ACC_CLEAR: mem_d[addr] = '0;
        ACC_ADD:   mem_d[addr] = mem_q[addr] + add_val;
        default:   ;
      endcase
    end
  end

  // Reads are combinational so a value added on the same edge is visible next cycle.
  assign rd_data = addr_ok ? mem_q[addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/conv_transpose2d_stream.sv
// Streaming transposed 2D convolution: scatters each input pixel's KxK products into
// an accumulator map, then drains the full output map in raster order.
module conv_transpose2d_stream
  import conv_tp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int IN_H   = 4,
  parameter int IN_W   = 6,
  parameter int IN_CH  = 2,
  parameter int K      = 3,
  parameter int STRIDE = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             w_we,
  input  logic [idx_w(IN_CH*K*K)-1:0]      w_addr,
  input  logic signed [DATA_W-1:0]         w_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_W-1:0]         in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_W-1:0]          out_data,
  output logic                             out_last,
  output logic                             busy
);

  localparam int OUT_H = out_dim(IN_H, STRIDE, K);
  localparam int OUT_W = out_dim(IN_W, STRIDE, K);
  localparam int OUT_N = OUT_H * OUT_W;
  localparam int NW    = IN_CH * K * K;
  localparam int WA_W  = idx_w(NW);
  localparam int MA_W  = idx_w(OUT_N);
  localparam int KC_W  = idx_w(K);
  localparam int CH_W  = idx_w(IN_CH);
  localparam int IY_W  = idx_w(IN_H);
  localparam int IX_W  = idx_w(IN_W);

  state_e                    state_q, state_d;
  logic [MA_W-1:0]           idx_q, idx_d;
  logic [KC_W-1:0]           kx_q, kx_d, ky_q, ky_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [IY_W-1:0]           iy_q, iy_d;
  logic [IX_W-1:0]           ix_q, ix_d;
  logic signed [DATA_W-1:0]  pix_q, pix_d;
  logic                      started_q, started_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic                      busy_q, busy_d;
  logic signed [DATA_W-1:0]  w_q [NW];
  logic signed [DATA_W-1:0]  w_d [NW];

  logic [WA_W-1:0]           w_idx;
  logic [MA_W-1:0]           scat_addr;
  logic signed [DATA_W-1:0]  w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]          add_val;
  acc_op_e                   acc_op;
  logic [MA_W-1:0]           acc_addr;
  logic [ACC_W-1:0]          acc_rd;
  logic                      last_pixel;
  logic                      last_tap;

  always_comb begin
    w_d = w_q;
    if (w_we && int'(w_addr) < NW) w_d[w_addr] = w_data;
  end

  // Scatter target and weight for the current kernel tap; product kept at full precision.
  always_comb begin
    w_idx     = WA_W'(int'(ch_q) * K * K + int'(ky_q) * K + int'(kx_q));
    scat_addr = MA_W'((int'(iy_q) * STRIDE + int'(ky_q)) * OUT_W
                      + int'(ix_q) * STRIDE + int'(kx_q));
    w_sel     = w_q[w_idx];
    prod      = (2*DATA_W)'(pix_q) * (2*DATA_W)'(w_sel);
    add_val   = ACC_W'(prod);
  end

  assign last_pixel = (ch_q == CH_W'(IN_CH - 1)) && (iy_q == IY_W'(IN_H - 1))
                      && (ix_q == IX_W'(IN_W - 1));
  assign last_tap   = (kx_q == KC_W'(K - 1)) && (ky_q == KC_W'(K - 1));

  always_comb begin
    acc_op   = ACC_NOP;
    acc_addr = idx_q;
    case (state_q)
      ST_CLEAR:   acc_op = ACC_CLEAR;
      ST_SCATTER: begin
        acc_op   = ACC_ADD;
        acc_addr = scat_addr;
      end
      ST_DRAIN:   acc_op = ACC_READ;
      default:    ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    ch_d        = ch_q;
    iy_d        = iy_q;
    ix_d        = ix_q;
    pix_d       = pix_q;
    started_d   = started_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_CLEAR: begin
        if (idx_q == MA_W'(OUT_N - 1)) begin
          idx_d      = '0;
          state_d    = ST_ACCEPT;
          in_ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          pix_d      = in_data;
          started_d  = 1'b1;
          kx_d       = '0;
          ky_d       = '0;
          in_ready_d = 1'b0;
          state_d    = ST_SCATTER;
        end
      end
      ST_SCATTER: begin
        if (kx_q == KC_W'(K - 1)) begin
          kx_d = '0;
          ky_d = ky_q + 1'b1;
        end else begin
          kx_d = kx_q + 1'b1;
        end
        if (last_tap) begin
          ky_d = '0;
          if (last_pixel) begin
            ch_d        = '0;
            iy_d        = '0;
            ix_d        = '0;
            started_d   = 1'b0;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_last_d  = (OUT_N == 1);
            state_d     = ST_DRAIN;
          end else begin
            if (ix_q == IX_W'(IN_W - 1)) begin
              ix_d = '0;
              if (iy_q == IY_W'(IN_H - 1)) begin
                iy_d = '0;
                ch_d = ch_q + 1'b1;
              end else begin
                iy_d = iy_q + 1'b1;
              end
            end else begin
              ix_d = ix_q + 1'b1;
            end
            in_ready_d = 1'b1;
            state_d    = ST_ACCEPT;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == MA_W'(OUT_N - 1)) begin
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_CLEAR;
          end else begin
            idx_d      = idx_q + 1'b1;
            out_last_d = (idx_q == MA_W'(OUT_N - 2));
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    busy_d = !(state_d == ST_ACCEPT && !started_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      ch_q        <= '0;
      iy_q        <= '0;
      ix_q        <= '0;
      pix_q       <= '0;
      started_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b1;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ch_q        <= ch_d;
      iy_q        <= iy_d;
      ix_q        <= ix_d;
      pix_q       <= pix_d;
      started_q   <= started_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      w_q         <= w_d;
    end
  end

  conv_tp_acc_map #(
    .ACC_W (ACC_W),
    .DEPTH (OUT_N),
    .ADDR_W(MA_W)
  ) u_acc_map (
    .clk    (clk),
    .rst    (rst),
    .op     (acc_op),
    .addr   (acc_addr),
    .add_val(add_val),
    .rd_data(acc_rd)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign out_data  = out_valid_q ? signed'(acc_rd) : '0;

endmodule

// File: tb/tb_conv_transpose2d_stream.sv
// Scoreboard bench: a gather-form reference model fills an expected queue per frame,
// and a negedge monitor checks every presented output pixel against it.
module tb_conv_transpose2d_stream;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 40;
  localparam int IN_H    = 4;
  localparam int IN_W    = 6;
  localparam int IN_CH   = 2;
  localparam int K       = 3;
  localparam int STRIDE  = 2;
  localparam int OUT_H   = (IN_H - 1) * STRIDE + K;
  localparam int OUT_W   = (IN_W - 1) * STRIDE + K;
  localparam int N       = OUT_H * OUT_W;
  localparam int NP      = IN_CH * IN_H * IN_W;
  localparam int NW      = IN_CH * K * K;
  localparam int WA_W    = $clog2(NW);
  localparam int TIMEOUT = 4000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     w_we = 1'b0;
  logic [WA_W-1:0]          w_addr = '0;
  logic signed [DATA_W-1:0] w_data = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;
  logic                     busy;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   pix[NP];
  int   wgt[NW];
  int   compared = 0;
  int   mismatched = 0;
  bit   throttle = 1'b0;
  bit   gap_armed = 1'b0;
  int   gap_cnt = 0;

  conv_transpose2d_stream #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .IN_H(IN_H), .IN_W(IN_W),
    .IN_CH(IN_CH), .K(K), .STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rand16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Each output pixel gathers every (ch, input pixel, tap) whose upsampled position lands on it.
  function automatic void build_expected();
    for (int oy = 0; oy < OUT_H; oy++) begin
      for (int ox = 0; ox < OUT_W; ox++) begin
        longint s = 0;
        exp_t   e;
        for (int c = 0; c < IN_CH; c++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              int dy = oy - ky;
              int dx = ox - kx;
              if (dy >= 0 && dx >= 0 && dy % STRIDE == 0 && dx % STRIDE == 0
                  && dy / STRIDE < IN_H && dx / STRIDE < IN_W)
                s += longint'(pix[c*IN_H*IN_W + (dy/STRIDE)*IN_W + dx/STRIDE])
                   * longint'(wgt[c*K*K + ky*K + kx]);
            end
        e.data = s[ACC_W-1:0];
        e.last = (oy * OUT_W + ox == N - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic load_weights();
    for (int i = 0; i < NW; i++) begin
      @(posedge clk); #1;
      w_we   = 1'b1;
      w_addr = WA_W'(i);
      w_data = 16'(wgt[i]);
    end
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic applyStimulus(input bit hold_valid, input int n_pix);
    for (int p = 0; p < n_pix; p++) begin
      int waited = 0;
      in_valid = 1'b1;
      in_data  = 16'(pix[p]);
      @(negedge clk);
      while (!in_ready && waited < TIMEOUT) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        checkOutput("in_handshake_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (p == 0) begin
        @(negedge clk);
        checkOutput("busy_after_first_pixel", 64'(busy), 64'd1);
        checkOutput("in_ready_in_scatter", 64'(in_ready), 64'd0);
      end
    end
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checkOutput("drain_timeout_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    int n = 0;
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", {out_data}, 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 2*N + 10) begin
      n++;
      @(negedge clk);
    end
    checkOutput("first_in_ready_cycle", 64'(n), 64'(N));
    checkOutput("busy_idle_accept", 64'(busy), 64'd0);
  endtask

  // Random backpressure, applied just after each active edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      gap_armed = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        checkOutput("out_data", {out_data}, {exp_q[0].data});
        if (out_ready) begin
          checkOutput("out_last", 64'(out_last), 64'(exp_q[0].last));
          if (out_last) begin
            gap_armed = 1'b1;
            gap_cnt   = 0;
          end
          void'(exp_q.pop_front());
        end
      end
    end else if (gap_armed) begin
      if (!in_ready) gap_cnt++;
      else begin
        checkOutput("clear_gap_cycles", 64'(gap_cnt), 64'(N));
        gap_armed = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    do_reset();

    $display("[TB] all-ones frame");
    foreach (wgt[i]) wgt[i] = 1;
    foreach (pix[i]) pix[i] = 1;
    load_weights();
    build_expected();
    applyStimulus(1'b0, NP);
    wait_drain();

    $display("[TB] random frames with throttled drain");
    throttle = 1'b1;
    for (int f = 0; f < 3; f++) begin
      foreach (wgt[i]) wgt[i] = rand16();
      foreach (pix[i]) pix[i] = rand16();
      load_weights();
      build_expected();
      applyStimulus(1'b0, NP);
      wait_drain();
    end

    $display("[TB] extreme-value frames");
    foreach (wgt[i]) wgt[i] = -32768;
    foreach (pix[i]) pix[i] = -32768;
    load_weights();
    build_expected();
    applyStimulus(1'b0, NP);
    wait_drain();
    foreach (pix[i]) pix[i] = 0;
    pix[$urandom_range(0, NP-1)] = -32768;
    build_expected();
    applyStimulus(1'b0, NP);
    wait_drain();

    $display("[TB] reset during scatter of third pixel");
    throttle = 1'b0;
    foreach (wgt[i]) wgt[i] = rand16();
    foreach (pix[i]) pix[i] = rand16();
    load_weights();
    applyStimulus(1'b0, 3);
    repeat (3) @(posedge clk);
    do_reset();
    foreach (wgt[i]) wgt[i] = 1;
    foreach (pix[i]) pix[i] = 1;
    load_weights();
    build_expected();
    applyStimulus(1'b0, NP);
    wait_drain();

    $display("[TB] back-to-back frames with in_valid held");
    throttle = 1'b1;
    foreach (wgt[i]) wgt[i] = rand16();
    load_weights();
    foreach (pix[i]) pix[i] = rand16();
    build_expected();
    applyStimulus(1'b1, NP);
    foreach (pix[i]) pix[i] = rand16();
    build_expected();
    applyStimulus(1'b1, NP);
    in_valid = 1'b0;
    wait_drain();

    repeat (N + 10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_transpose2d_stream.md
# conv_transpose2d_stream

Streaming single-engine transposed 2D convolution, square kernel, configurable stride, multi-input-channel accumulation into one output map. It consumes an input feature map one pixel per handshake. Each pixel's K×K weighted contributions are scattered into an on-chip accumulator map. After the last input pixel, the full output map is drained in raster order with backpressure. It is the parametrised successor to the fixed pass-through transposed-conv operator wrapper, and sits between the input-tensor streamer and the output writer in the operator pipeline.

## Interface
Parameters:
- DATA_W, 16: signed input/weight width
- ACC_W, 40: signed accumulator/output width
- IN_H, 4: input height
- IN_W, 6: input width (asymmetric allowed)
- IN_CH, 2: input channels summed into the single output map
- K, 3: kernel size
- STRIDE, 2: upsampling stride
- Derived: OUT_H = (IN_H-1)*STRIDE+K; OUT_W = (IN_W-1)*STRIDE+K; padding = 0; output_padding = 0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- w_we  in  1  weight write strobe
- w_addr  in  clog2(IN_CH*K*K)  weight index, ch*K*K + ky*K + kx
- w_data  in  DATA_W  signed weight
- in_valid  in  1  input pixel valid
- in_ready  out  1  engine can accept a pixel
- in_data  in  DATA_W  signed pixel, order: ch, then row, then col
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  signed accumulated output pixel
- out_last  out  1  marks final output pixel (OUT_H*OUT_W-th)
- busy  out  1  high in any state except ACCEPT while no pixel of the current frame has been taken

## Operation
- States: CLEAR, ACCEPT, SCATTER, DRAIN.
- CLEAR: zero one accumulator per cycle; OUT_H*OUT_W cycles; then ACCEPT.
- ACCEPT: in_ready=1. On in_valid&&in_ready, latch pixel, its (ch,iy,ix) counters → SCATTER.
- SCATTER: K*K cycles, kx inner, ky outer. Each cycle does acc[(iy*STRIDE+ky)*OUT_W + ix*STRIDE+kx] += sext(pixel*w[ch][ky][kx]), with a full-precision 2*DATA_W product sign-extended to ACC_W.
- At SCATTER end: if the pixel was the last one (ch=IN_CH-1, iy=IN_H-1, ix=IN_W-1), go to DRAIN; else return to ACCEPT.
- Accumulation wraps modulo 2^ACC_W; there is no saturation.
- DRAIN: present acc[0..OUT_H*OUT_W-1] in raster order. The index advances only on out_valid&&out_ready. After the transfer with out_last, go to CLEAR.
- Weights live in a register array, writable in any state. A write takes effect from the next cycle's read. Writing during a frame is legal but mixes weights; software's responsibility.
- Input counters wrap ix→iy→ch. They reset to 0 on frame completion.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=1, state=CLEAR, all counters 0. Weights are reset to 0. After rst deasserts, CLEAR runs.
- First in_ready: cycle OUT_H*OUT_W after reset release.
- Pixel throughput: one per K*K+1 cycles (1 ACCEPT + K*K SCATTER). in_ready is deasserted during SCATTER.
- out_valid rises the cycle after the final SCATTER cycle. out_data/out_last are stable while out_valid&&!out_ready. out_valid can be high on consecutive cycles (one pixel per cycle at full ready).
- Frame latency, from the last input handshake to the first out_valid: K*K+1 cycles.
- rst mid-frame: immediate abort. Outputs go to reset values and accumulators are re-cleared via CLEAR. Weights are also reset.
- in_valid held in SCATTER/DRAIN/CLEAR is ignored, with no capture.

## Structure
- Package conv_tp_pkg: state enum, a function for the derived OUT_H/OUT_W, and a clog2-based index-width helper.
- One sub-module, conv_tp_acc_map: the OUT_H*OUT_W×ACC_W accumulator register array. It has a single read-modify-write port with the operations clear/add/read.
- The top holds the FSM, counters, weight array and multiplier.

## Test plan
- IN 2×2, CH1, K3, S2, all weights 1, all pixels 1 → 5×5 output. (0,0)=1, (0,2)=2, (2,2)=4, (2,1)=2, (4,4)=1; out_last on the 25th pixel.
- CH2, K3, S1, IN 1×1, ch0 pixel 3, ch1 pixel −2, all weights w=ky*3+kx → out[ky][kx]=w.
- DATA_W 16: pixel −32768, weight −32768, IN 1×1, K1 → out_data=2^30. ACC_W 8 with repeated overlap → modulo-256 wrap observed.
- Random out_ready throttling (~50%) during DRAIN → out_data stable while stalled, every index emitted exactly once, in order.
- Assert rst during SCATTER of the 3rd pixel, then run a fresh all-ones frame → output identical to the clean run (no residue).
- Back-to-back frames with in_valid always high → in_ready=0 for OUT_H*OUT_W cycles between frames; second frame output is correct.
